// File: rtl/fun_pkg.sv
// Shared widths, cube-root step constants and FSM encoding for fun_core.
package fun_pkg;

  localparam int OP_W   = 8;
  localparam int RES_W  = 11;
  localparam int ROOT_W = 3;
  localparam int PROD_W = 2 * OP_W;
  localparam int T_W    = 9;
  localparam int S_W    = 3;

  localparam logic [S_W-1:0] S_INIT = 3'd6;
  localparam logic [S_W-1:0] S_STEP = 3'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CBRT_SHIFT = 3'd1,
    CBRT_MUL   = 3'd2,
    CBRT_CMP   = 3'd3,
    FIN_MUL    = 3'd4,
    DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// 8x8 -> 16 unsigned shift-add multiplier: one load cycle, then one
// multiplier bit per cycle; done pulses for one cycle with prod valid.
module shift_add_mul
  import fun_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] prod,
  output logic              done
);

  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [OP_W-1:0]   mplier;
  logic [2:0]        cnt;
  logic              running;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        mcand   <= {{(PROD_W-OP_W){1'b0}}, x};
        mplier  <= y;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  // acc is only rewritten by a new go, so prod stays stable after done.
  assign prod = acc;

endmodule

// File: rtl/fun_core.sv
// result = a * floor(cbrt(b)) using a restoring bit-serial cube root and a
// single shared shift-add multiplier, with a start/busy handshake.
module fun_core
  import fun_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic             start,
  output logic [RES_W-1:0] result,
  output logic             busy
);

  state_t            state;
  state_t            state_nx;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   x_q;
  logic [ROOT_W-1:0] y_q;
  logic [S_W-1:0]    s_q;
  logic              mul_fired;

  logic              mul_go;
  logic              mul_done;
  logic [OP_W-1:0]   mul_x;
  logic [OP_W-1:0]   mul_y;
  logic [PROD_W-1:0] mul_prod;
  logic [T_W-1:0]    t_val;
  logic              take;

  // Trial subtrahend (3p+1) << s; p = y(y+1) never exceeds 42 here.
  function automatic logic [T_W-1:0] root_trial(input logic [T_W-1:0] p,
                                                input logic [S_W-1:0] s);
    logic [T_W-1:0] t3p1;
    t3p1 = (p << 1) + p + T_W'(1);
    return t3p1 << s;
  endfunction

  function automatic logic [RES_W-1:0] fit_result(input logic [PROD_W-1:0] p);
    if (|p[PROD_W-1:RES_W]) return {RES_W{1'b1}};
    return p[RES_W-1:0];
  endfunction

  shift_add_mul u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (mul_go),
    .x    (mul_x),
    .y    (mul_y),
    .prod (mul_prod),
    .done (mul_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (start) state_nx = CBRT_SHIFT;
      CBRT_SHIFT: state_nx = CBRT_MUL;
      CBRT_MUL:   if (mul_done) state_nx = CBRT_CMP;
      CBRT_CMP:   state_nx = (s_q != '0) ? CBRT_SHIFT : FIN_MUL;
      FIN_MUL:    if (mul_done) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Multiplier operand mux: y*(y+1) during the root, a*y for the product.
  always_comb begin
    mul_go = 1'b0;
    mul_x  = a_q;
    mul_y  = {{(OP_W-ROOT_W){1'b0}}, y_q};
    if (state == CBRT_MUL) begin
      mul_x = {{(OP_W-ROOT_W){1'b0}}, y_q};
      mul_y = {{(OP_W-ROOT_W){1'b0}}, y_q} + OP_W'(1);
    end
    if ((state == CBRT_MUL || state == FIN_MUL) && !mul_fired) mul_go = 1'b1;
  end

  assign t_val = root_trial(mul_prod[T_W-1:0], s_q);
  assign take  = ({1'b0, x_q} >= t_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      mul_fired <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a_i;
            x_q  <= b_i;
            y_q  <= '0;
            s_q  <= S_INIT;
            busy <= 1'b1;
          end
        end
        CBRT_SHIFT: y_q <= y_q << 1;
        CBRT_MUL, FIN_MUL: begin
          if (mul_go)        mul_fired <= 1'b1;
          else if (mul_done) mul_fired <= 1'b0;
        end
        CBRT_CMP: begin
          // take guarantees t <= x <= 255, so the low byte is the full value.
          if (take) begin
            x_q <= x_q - t_val[OP_W-1:0];
            y_q <= y_q + ROOT_W'(1);
          end
          if (s_q != '0) s_q <= s_q - S_STEP;
        end
        DONE: begin
          result <= fit_result(mul_prod);
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fun_core.sv
// Randomized and directed bench for fun_core against a floor-cube-root model.
module tb_fun_core;

  logic        clk;
  logic        rst;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        start;
  logic [10:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int lat_ref  = -1;

  fun_core dut (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a_i),
    .b_i    (b_i),
    .start  (start),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int a, input int b);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return a * r;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [10:0] res, output int lat,
                        output logic rose, output logic tmo);
    @(negedge clk);
    a_i = a; b_i = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rose = busy;
    lat = 0;
    while (busy && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = busy;
    res = result;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; a_i = 8'd0; b_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++;
    if (result !== 11'd0) begin failures++; $display("FAIL reset_result got=%0d want=0", result); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b want=0", busy); end
  endtask

  task automatic test_directed;
    int ta [10] = '{5, 3, 9, 255, 255, 1, 1, 0, 77, 0};
    int tb [10] = '{27, 64, 125, 200, 255, 7, 8, 200, 0, 0};
    logic [10:0] res; int lat; logic rose, tmo; int exp;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i][7:0], tb[i][7:0], res, lat, rose, tmo);
      exp = model(ta[i], tb[i]);
      if (lat_ref < 0 && !tmo) lat_ref = lat;
      checks++;
      if (rose !== 1'b1) begin failures++; $display("FAIL dir_busy_rise a=%0d b=%0d got=%0b want=1", ta[i], tb[i], rose); end
      checks++;
      if (tmo !== 1'b0) begin failures++; $display("FAIL dir_timeout a=%0d b=%0d busy stuck", ta[i], tb[i]); end
      checks++;
      if (res !== exp[10:0]) begin failures++; $display("FAIL dir_result a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], res, exp); end
      checks++;
      if (lat > 64 || lat != lat_ref) begin failures++; $display("FAIL dir_latency a=%0d b=%0d got=%0d want=%0d (<=64)", ta[i], tb[i], lat, lat_ref); end
    end
  endtask

  task automatic test_random;
    logic [10:0] res; int lat; logic rose, tmo; int a, b, exp;
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_op(a[7:0], b[7:0], res, lat, rose, tmo);
      exp = model(a, b);
      checks++;
      if (tmo !== 1'b0 || rose !== 1'b1) begin failures++; $display("FAIL rnd_handshake a=%0d b=%0d rose=%0b stuck=%0b", a, b, rose, tmo); end
      checks++;
      if (res !== exp[10:0]) begin failures++; $display("FAIL rnd_result a=%0d b=%0d got=%0d want=%0d", a, b, res, exp); end
      checks++;
      if (lat != lat_ref) begin failures++; $display("FAIL rnd_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, lat_ref); end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    a_i = 8'd5; b_i = 8'd27; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a_i = 8'd2; b_i = 8'd27; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (busy && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_timeout busy stuck"); end
    checks++;
    if (result !== 11'd15) begin failures++; $display("FAIL ign_result got=%0d want=15", result); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_requeued busy got=%0b want=0", busy); end
  endtask

  task automatic test_async_reset;
    logic [10:0] res; int lat; logic rose, tmo;
    run_op(8'd9, 8'd125, res, lat, rose, tmo);
    @(negedge clk);
    a_i = 8'd255; b_i = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b want=0", busy); end
    checks++;
    if (result !== 11'd0) begin failures++; $display("FAIL arst_result got=%0d want=0", result); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    run_op(8'd3, 8'd64, res, lat, rose, tmo);
    checks++;
    if (res !== 11'd12 || tmo !== 1'b0) begin failures++; $display("FAIL arst_after got=%0d want=12 stuck=%0b", res, tmo); end
    checks++;
    if (lat != lat_ref) begin failures++; $display("FAIL arst_latency got=%0d want=%0d", lat, lat_ref); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] res, prev; int lat; logic rose, tmo; int a, b, exp;
    run_op(8'd255, 8'd255, prev, lat, rose, tmo);
    @(negedge clk);
    a_i = 8'd1; b_i = 8'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result !== prev) begin failures++; $display("FAIL b2b_hold busy=%0b result=%0d want busy=1 result=%0d", busy, result, prev); end
    lat = 0;
    while (busy && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (result !== 11'd2 || lat != lat_ref) begin failures++; $display("FAIL b2b_first got=%0d lat=%0d want=2 lat=%0d", result, lat, lat_ref); end
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_op(a[7:0], b[7:0], res, lat, rose, tmo);
      exp = model(a, b);
      checks++;
      if (res !== exp[10:0] || tmo !== 1'b0) begin failures++; $display("FAIL b2b_result a=%0d b=%0d got=%0d want=%0d", a, b, res, exp); end
      checks++;
      if (lat != lat_ref || rose !== 1'b1) begin failures++; $display("FAIL b2b_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, lat_ref); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
